mem_arbiter: RTL and testbench

Arbitrates the single physical-memory port between the instruction cache (read-only) and the data cache (read/write) of the pipelined LC-3b core. Only one line transaction is in flight at a time. Contention is resolved with data-side priority plus an anti-starvation alternation rule, so a stalled MEM stage clears first but instruction fetch is never starved. Address, write data and command are registered at grant and held stable on the memory side until the memory responds.

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 78 +++++++
 tb/tb_mem_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles I-cache, D-cache and physical-memory signals of the arbiter
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  logic                  icache_read;
  logic [ADDR_WIDTH-1:0] icache_address;
  logic [LINE_WIDTH-1:0] icache_rdata;
  logic                  icache_resp;
  logic                  dcache_read;
  logic                  dcache_write;
  logic [ADDR_WIDTH-1:0] dcache_address;
  logic [LINE_WIDTH-1:0] dcache_wdata;
  logic [LINE_WIDTH-1:0] dcache_rdata;
  logic                  dcache_resp;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;
  modport slave (
    input  icache_read, icache_address, dcache_read, dcache_write, dcache_address,
           dcache_wdata, pmem_rdata, pmem_resp,
    output icache_rdata, icache_resp, dcache_rdata, dcache_resp, pmem_read,
           pmem_write, pmem_address, pmem_wdata
  );
  modport master (
    output icache_read, icache_address, dcache_read, dcache_write, dcache_address,
           dcache_wdata, pmem_rdata, pmem_resp,
    input  icache_rdata, icache_resp, dcache_rdata, dcache_resp, pmem_read,
           pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter, D-side priority with I/D alternation under contention
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_arbiter_if.slave   bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  logic [1:0]            state_q, state_d;
  logic                  last_q, last_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  i_req, d_req, grant_d;
  assign i_req   = bus.icache_read;
  assign d_req   = bus.dcache_read | bus.dcache_write;
  assign grant_d = d_req & ~(i_req & last_q);
  // grant from IDLE latches the memory-side command; pmem_resp returns to IDLE
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_q == IDLE) begin
      if (grant_d) begin
        state_d = SERVE_D;
        last_d  = 1'b1;
        addr_d  = bus.dcache_address;
        wr_d    = bus.dcache_write;
        rd_d    = ~bus.dcache_write;
        wdata_d = bus.dcache_write ? bus.dcache_wdata : wdata_q;
      end else if (i_req) begin
        state_d = SERVE_I;
        last_d  = 1'b0;
        addr_d  = bus.icache_address;
        rd_d    = 1'b1;
        wr_d    = 1'b0;
      end
    end else if (bus.pmem_resp) begin
      state_d = IDLE;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
    end
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign bus.pmem_read    = rd_q;
  assign bus.pmem_write   = wr_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
  assign bus.icache_rdata = bus.pmem_rdata;
  assign bus.dcache_rdata = bus.pmem_rdata;
  assign bus.icache_resp  = (state_q == SERVE_I) & bus.pmem_resp;
  assign bus.dcache_resp  = (state_q == SERVE_D) & bus.pmem_resp;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  mem_arbiter_if bus ();
  mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic strobes(input string tag, input logic rd, input logic wr);
    chk({tag, "_rd"}, 128'(bus.pmem_read), 128'(rd));
    chk({tag, "_wr"}, 128'(bus.pmem_write), 128'(wr));
  endtask
  task automatic resps(input string tag, input logic ir, input logic dr);
    chk({tag, "_iresp"}, 128'(bus.icache_resp), 128'(ir));
    chk({tag, "_dresp"}, 128'(bus.dcache_resp), 128'(dr));
  endtask
  initial begin
    logic [127:0] a5 = {16{8'hA5}};
    logic [127:0] wd = 128'h0123456789ABCDEF0123456789ABCDEF;
    bus.icache_read = 0; bus.icache_address = '0;
    bus.dcache_read = 0; bus.dcache_write = 0; bus.dcache_address = '0; bus.dcache_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 0;
    cyc(); cyc();
    strobes("reset", 0, 0);
    resps("reset", 0, 0);
    chk("reset_addr", 128'(bus.pmem_address), 128'h0);
    chk("reset_wdata", bus.pmem_wdata, 128'h0);
    rst_n = 1;
    // lone I read, 4-cycle memory
    bus.icache_read = 1; bus.icache_address = 16'h1230;
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      strobes("iread_wait", 1, 0);
      chk("iread_addr", 128'(bus.pmem_address), 128'h1230);
      resps("iread_wait", 0, 0);
    end
    cyc(); bus.pmem_resp = 1; bus.pmem_rdata = a5; #1;
    strobes("iread_last", 1, 0);
    resps("iread_done", 1, 0);
    chk("iread_rdata", bus.icache_rdata, a5);
    cyc(); bus.pmem_resp = 0; bus.icache_read = 0; #1;
    strobes("iread_turn", 0, 0);
    resps("iread_turn", 0, 0);
    // lone D write, 2-cycle memory
    bus.dcache_write = 1; bus.dcache_address = 16'h8000; bus.dcache_wdata = wd;
    cyc(); #1;
    strobes("dwr", 0, 1);
    chk("dwr_addr", 128'(bus.pmem_address), 128'h8000);
    chk("dwr_wdata", bus.pmem_wdata, wd);
    cyc(); bus.pmem_resp = 1; #1;
    strobes("dwr_last", 0, 1);
    resps("dwr_done", 0, 1);
    cyc(); bus.pmem_resp = 0; bus.dcache_write = 0; #1;
    strobes("dwr_turn", 0, 0);
    // simultaneous requests from reset
    rst_n = 0; cyc(); rst_n = 1;
    bus.icache_read = 1; bus.icache_address = 16'h1000;
    bus.dcache_read = 1; bus.dcache_address = 16'h2000;
    cyc(); #1;
    strobes("sim_d", 1, 0);
    chk("sim_d_addr", 128'(bus.pmem_address), 128'h2000);
    bus.pmem_resp = 1; #1;
    resps("sim_d_done", 0, 1);
    cyc(); bus.pmem_resp = 0; bus.dcache_read = 0; #1;
    strobes("sim_turn", 0, 0);
    cyc(); #1;
    strobes("sim_i", 1, 0);
    chk("sim_i_addr", 128'(bus.pmem_address), 128'h1000);
    bus.pmem_resp = 1; #1;
    resps("sim_i_done", 1, 0);
    cyc(); bus.pmem_resp = 0; bus.icache_read = 0; #1;
    strobes("sim_i_turn", 0, 0);
    // continuous contention: expect D, I, D, I
    bus.icache_read = 1; bus.icache_address = 16'h1100;
    bus.dcache_read = 1; bus.dcache_address = 16'h2200;
    for (int g = 0; g < 4; g++) begin
      cyc(); #1;
      strobes("cont", 1, 0);
      chk("cont_addr", 128'(bus.pmem_address), (g % 2 == 0) ? 128'h2200 : 128'h1100);
      bus.pmem_resp = 1; #1;
      resps("cont_done", g % 2 == 1, g % 2 == 0);
      cyc(); bus.pmem_resp = 0; #1;
      strobes("cont_turn", 0, 0);
    end
    bus.icache_read = 0; bus.dcache_read = 0;
    cyc();
    // reset mid-transaction
    bus.dcache_write = 1; bus.dcache_address = 16'h3000; bus.dcache_wdata = a5;
    cyc(); #1;
    strobes("rmid_pre", 0, 1);
    rst_n = 0; bus.dcache_write = 0;
    cyc(); #1;
    strobes("rmid_post", 0, 0);
    chk("rmid_addr", 128'(bus.pmem_address), 128'h0);
    rst_n = 1; bus.pmem_resp = 1; #1;
    resps("rmid_resp", 0, 0);
    cyc(); bus.pmem_resp = 0; #1;
    strobes("rmid_idle", 0, 0);
    // spurious pmem_resp in IDLE
    bus.pmem_resp = 1; #1;
    resps("spur", 0, 0);
    cyc(); bus.pmem_resp = 0; #1;
    strobes("spur_idle", 0, 0);
    bus.icache_read = 1; bus.icache_address = 16'h4560;
    cyc(); #1;
    strobes("spur_i", 1, 0);
    chk("spur_i_addr", 128'(bus.pmem_address), 128'h4560);
    cyc(); bus.pmem_resp = 1; bus.pmem_rdata = wd; #1;
    resps("spur_i_done", 1, 0);
    chk("spur_i_rdata", bus.icache_rdata, wd);
    cyc(); bus.pmem_resp = 0; bus.icache_read = 0; #1;
    strobes("spur_i_turn", 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
